pes_usr_ctrl: RTL and testbench

Command sequencer for the 4-bit universal shift register (pes_usr).
- Accepts load/shift commands over a valid/ready handshake.
- Drives the register's mode and parallel-data inputs cycle by cycle, then captures its output after the command completes.
- Sits between a host/bus-side requester and one pes_usr instance; pes_usr q feeds back into usr_q.

---
 rtl/pes_usr_pkg.sv | 39 +++
 rtl/pes_usr_cmd_buf.sv | 40 ++++
 rtl/pes_usr_ctrl.sv | 156 +++++++++++++++
 tb/tb_pes_usr_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pes_usr_pkg.sv
// rtl/pes_usr_pkg.sv - shared constants, FSM state type and helpers for the pes_usr controller
// Purpose: mode/op encodings and state typedef used by pes_usr_ctrl and pes_usr_cmd_buf.
// Ports: none (package).
package pes_usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_SHR      = 2'b01;
  localparam logic [1:0] OP_SHL      = 2'b10;
  localparam logic [1:0] OP_LOAD_SHL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_SETTLE
  } state_t;

  // First state of a freshly launched command.
  function automatic state_t launch_state(input logic [1:0] op, input logic amt_nz);
    if (op == OP_LOAD || op == OP_LOAD_SHL) return ST_LOAD;
    else if (amt_nz)                        return ST_SHIFT;
    else                                    return ST_SETTLE;
  endfunction

  // Register mode driven while sitting in a given state.
  function automatic logic [1:0] state_mode(input state_t st, input logic [1:0] op);
    case (st)
      ST_LOAD:  return MODE_LOAD;
      ST_SHIFT: return (op == OP_SHR) ? MODE_SHR : MODE_SHL;
      default:  return MODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/pes_usr_cmd_buf.sv
// rtl/pes_usr_cmd_buf.sv - one-entry pending command register
// Purpose: holds one command accepted while the controller is busy.
// Ports: clk, rst (async active-low); wr/wr_op/wr_data/wr_amt load the entry;
//        rd empties it; full/op/data/amt present the stored entry.
module pes_usr_cmd_buf
  import pes_usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [1:0]       wr_op,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AMT_W-1:0] wr_amt,
  input  logic             rd,
  output logic             full,
  output logic [1:0]       op,
  output logic [WIDTH-1:0] data,
  output logic [AMT_W-1:0] amt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      op   <= OP_LOAD;
      data <= '0;
      amt  <= '0;
    end else if (wr) begin
      full <= 1'b1;
      op   <= wr_op;
      data <= wr_data;
      amt  <= wr_amt;
    end else if (rd) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/pes_usr_ctrl.sv
// rtl/pes_usr_ctrl.sv - load/shift command sequencer for the pes_usr shift register
// Purpose: accepts LOAD/SHR/SHL/LOAD_SHL commands, drives pes_usr mode/in per cycle,
//          captures pes_usr q after a settle cycle and pulses done.
// Ports: clk, rst (async active-low); cmd_valid/cmd_ready/cmd_op/cmd_data/cmd_amt command
//        handshake; usr_mode/usr_in to pes_usr, usr_q from pes_usr; result/done/busy status.
// Config: define PES_USR_CTRL_QUEUE_EN for a one-entry pending command buffer.
module pes_usr_ctrl
  import pes_usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [AMT_W-1:0] cmd_amt,
  output logic [1:0]       usr_mode,
  output logic [WIDTH-1:0] usr_in,
  input  logic [WIDTH-1:0] usr_q,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  state_t           state, state_next;
  logic [1:0]       op_r, op_next;
  logic [AMT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] result_next, usr_in_next;
  logic             done_next;
  logic             accept;
  logic             launch;
  logic [1:0]       l_op;
  logic [WIDTH-1:0] l_data;
  logic [AMT_W-1:0] l_amt;

  assign accept = cmd_valid & cmd_ready;

`ifdef PES_USR_CTRL_QUEUE_EN
  logic             pend_full, pend_wr, pend_rd;
  logic [1:0]       pend_op;
  logic [WIDTH-1:0] pend_data;
  logic [AMT_W-1:0] pend_amt;

  pes_usr_cmd_buf #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_cmd_buf (
    .clk     (clk),
    .rst     (rst),
    .wr      (pend_wr),
    .wr_op   (cmd_op),
    .wr_data (cmd_data),
    .wr_amt  (cmd_amt),
    .rd      (pend_rd),
    .full    (pend_full),
    .op      (pend_op),
    .data    (pend_data),
    .amt     (pend_amt)
  );

  assign cmd_ready = !pend_full;
`else
  logic ready_r;
  assign cmd_ready = ready_r;
`endif

  always_comb begin
    state_next  = state;
    op_next     = op_r;
    cnt_next    = cnt;
    result_next = result;
    done_next   = 1'b0;
    launch      = 1'b0;
    l_op        = cmd_op;
    l_data      = cmd_data;
    l_amt       = cmd_amt;
`ifdef PES_USR_CTRL_QUEUE_EN
    pend_rd     = 1'b0;
    pend_wr     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (accept) launch = 1'b1;
      end
      ST_LOAD: begin
        // cnt still holds the amount latched at launch.
        state_next = (op_r == OP_LOAD_SHL && cnt != '0) ? ST_SHIFT : ST_SETTLE;
      end
      ST_SHIFT: begin
        cnt_next = cnt - AMT_W'(1);
        if (cnt <= AMT_W'(1)) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        done_next   = 1'b1;
        result_next = usr_q;
        state_next  = ST_IDLE;
`ifdef PES_USR_CTRL_QUEUE_EN
        // Pending entry has priority; otherwise a command arriving now launches directly.
        if (pend_full) begin
          launch  = 1'b1;
          pend_rd = 1'b1;
          l_op    = pend_op;
          l_data  = pend_data;
          l_amt   = pend_amt;
        end else if (accept) begin
          launch = 1'b1;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase

`ifdef PES_USR_CTRL_QUEUE_EN
    // Accepted commands not consumed by a direct launch park in the buffer.
    pend_wr = accept && !(launch && !pend_rd);
`endif

    usr_in_next = usr_in;
    if (launch) begin
      op_next    = l_op;
      cnt_next   = l_amt;
      state_next = launch_state(l_op, l_amt != '0);
      if (state_next == ST_LOAD) usr_in_next = l_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      op_r     <= OP_LOAD;
      cnt      <= '0;
      usr_mode <= MODE_HOLD;
      usr_in   <= '0;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      op_r     <= op_next;
      cnt      <= cnt_next;
      usr_mode <= state_mode(state_next, op_next);
      usr_in   <= usr_in_next;
      result   <= result_next;
      done     <= done_next;
      busy     <= (state_next != ST_IDLE);
    end
  end

`ifndef PES_USR_CTRL_QUEUE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_r <= 1'b1;
    else      ready_r <= (state_next == ST_IDLE);
  end
`endif

endmodule

// File: tb/tb_pes_usr_ctrl.sv
// tb/tb_pes_usr_ctrl.sv - directed self-checking bench for pes_usr_ctrl with a pes_usr model
module tb_pes_usr_ctrl;

  localparam int WIDTH = 4;
  localparam int AMT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [AMT_W-1:0] cmd_amt = '0;
  logic [1:0]       usr_mode;
  logic [WIDTH-1:0] usr_in;
  logic [WIDTH-1:0] usr_q;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pes_usr_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_amt   (cmd_amt),
    .usr_mode  (usr_mode),
    .usr_in    (usr_in),
    .usr_q     (usr_q),
    .result    (result),
    .done      (done),
    .busy      (busy)
  );

  // Behavioural pes_usr: zero-fill shifts, parallel load on mode 11.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) usr_q <= '0;
    else begin
      case (usr_mode)
        2'b01:   usr_q <= {1'b0, usr_q[WIDTH-1:1]};
        2'b10:   usr_q <= {usr_q[WIDTH-2:0], 1'b0};
        2'b11:   usr_q <= usr_in;
        default: usr_q <= usr_q;
      endcase
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the command transfers on the following rising edge (edge 0).
  // Returns at the negedge of cycle 1.
  task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [1:0] amt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_amt   = amt;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mode",   8'(usr_mode), 8'h0);
    check("rst_in",     8'(usr_in),   8'h0);
    check("rst_result", 8'(result),   8'h0);
    check("rst_done",   8'(done),     8'h0);
    check("rst_busy",   8'(busy),     8'h0);
    rst = 1'b1;
    step();
    check("rst_ready",  8'(cmd_ready), 8'h1);

    // LOAD 1100: mode 11 c1, 00 c2, done c3
    send(2'b00, 4'b1100, 2'd0);
    check("ld_c1_mode",  8'(usr_mode),  8'h3);
    check("ld_c1_in",    8'(usr_in),    8'hC);
    check("ld_c1_busy",  8'(busy),      8'h1);
    check("ld_c1_ready", 8'(cmd_ready), 8'h0);
    step();
    check("ld_c2_mode",  8'(usr_mode),  8'h0);
    check("ld_c2_done",  8'(done),      8'h0);
    step();
    check("ld_c3_done",  8'(done),      8'h1);
    check("ld_c3_res",   8'(result),    8'hC);
    check("ld_c3_busy",  8'(busy),      8'h0);

    // LOAD 1000 then SHR amt=3
    send(2'b00, 4'b1000, 2'd0);
    check("ld_c1_done_clr", 8'(done), 8'h0);
    step(); step();
    check("ld8_done", 8'(done),   8'h1);
    check("ld8_res",  8'(result), 8'h8);
    send(2'b01, 4'b0000, 2'd3);
    check("shr_c1_mode", 8'(usr_mode), 8'h1);
    step();
    check("shr_c2_mode", 8'(usr_mode), 8'h1);
    step();
    check("shr_c3_mode", 8'(usr_mode), 8'h1);
    step();
    check("shr_c4_mode", 8'(usr_mode), 8'h0);
    check("shr_c4_done", 8'(done),     8'h0);
    step();
    check("shr_c5_done", 8'(done),     8'h1);
    check("shr_c5_res",  8'(result),   8'h1);

    // LOAD_SHL 0011 amt=2: modes 11,10,10,00; done c5
    send(2'b11, 4'b0011, 2'd2);
    check("lsl_c1_mode", 8'(usr_mode), 8'h3);
    step();
    check("lsl_c2_mode", 8'(usr_mode), 8'h2);
    step();
    check("lsl_c3_mode", 8'(usr_mode), 8'h2);
    step();
    check("lsl_c4_mode", 8'(usr_mode), 8'h0);
    check("lsl_c4_done", 8'(done),     8'h0);
    step();
    check("lsl_c5_done", 8'(done),     8'h1);
    check("lsl_c5_res",  8'(result),   8'hC);

    // SHL amt=0: straight to settle, done c2, result unchanged q
    send(2'b10, 4'b0101, 2'd0);
    check("shl0_c1_mode", 8'(usr_mode), 8'h0);
    check("shl0_c1_busy", 8'(busy),     8'h1);
    check("shl0_c1_done", 8'(done),     8'h0);
    step();
    check("shl0_c2_done", 8'(done),     8'h1);
    check("shl0_c2_res",  8'(result),   8'hC);
    check("shl0_c2_in",   8'(usr_in),   8'h3);

    // Reset mid-shift aborts the command
    send(2'b01, 4'b0000, 2'd3);
    step();
    check("abort_pre_mode", 8'(usr_mode), 8'h1);
    rst = 1'b0;
    #1;
    check("abort_mode", 8'(usr_mode), 8'h0);
    check("abort_busy", 8'(busy),     8'h0);
    check("abort_res",  8'(result),   8'h0);
    check("abort_done", 8'(done),     8'h0);
    step();
    rst = 1'b1;
    repeat (3) begin
      step();
      check("abort_no_done", 8'(done), 8'h0);
    end
    send(2'b00, 4'b1010, 2'd0);
    step(); step();
    check("post_ld_done", 8'(done),   8'h1);
    check("post_ld_res",  8'(result), 8'hA);
    step();

`ifdef PES_USR_CTRL_QUEUE_EN
    // Back-to-back LOAD 1100 then SHR amt=1
    send(2'b00, 4'b1100, 2'd0);
    check("q_c1_ready", 8'(cmd_ready), 8'h1);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_data  = 4'b0000;
    cmd_amt   = 2'd1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    step();
    check("q_c2_ready", 8'(cmd_ready), 8'h0);
    check("q_c2_mode",  8'(usr_mode),  8'h0);
    step();
    check("q_c3_done",  8'(done),      8'h1);
    check("q_c3_res",   8'(result),    8'hC);
    check("q_c3_mode",  8'(usr_mode),  8'h1);
    check("q_c3_ready", 8'(cmd_ready), 8'h1);
    step();
    check("q_c4_done",  8'(done),      8'h0);
    step();
    check("q_c5_done",  8'(done),      8'h1);
    check("q_c5_res",   8'(result),    8'h6);
    step();
    check("q_c6_busy",  8'(busy),      8'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
